// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station_pkg
//  Description : Shared opcode constants, FSM state encoding, operand
//                sentinel and station tags for the reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
package reservation_station_pkg;

    // Dispatched operation encoding
    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;

    // Station FSM encoding
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_OPS  = 2'd1;
    localparam logic [1:0] c_ST_EXEC      = 2'd2;
    localparam logic [1:0] c_ST_BROADCAST = 2'd3;

    // Value parked in the operand registers while the station is free
    localparam logic [15:0] c_OPERAND_SENTINEL = 16'hFFF0;

    // Producer tags; zero means the value is already present
    localparam logic [2:0] c_FREE_REGISTER     = 3'd0;
    localparam logic [2:0] c_RES_STATION_ADD1  = 3'd1;
    localparam logic [2:0] c_RES_STATION_ADD2  = 3'd2;

    // A broadcast satisfies an operand only when its tag is a real producer
    function automatic logic f_tag_hit(input logic       valid,
                                       input logic [2:0] cdb_tag,
                                       input logic [2:0] q_tag);
        return valid && (cdb_tag != c_FREE_REGISTER) && (cdb_tag == q_tag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_alu.sv
`default_nettype none
// ============================================================================
//  Module      : rs_alu
//  Description : Combinational 16-bit ALU for the adder reservation station.
//                Arithmetic wraps modulo 2^16; unknown opcodes pass Vj.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_alu
    import reservation_station_pkg::*;
(
    input  logic [2:0]  Opcode,
    input  logic [15:0] Vj,
    input  logic [15:0] Vk,
    output logic [15:0] Result
);

    // Select the operation result from the latched opcode
    always_comb begin
        Result = Vj;
        case (Opcode)
            c_OP_ADD: Result = Vj + Vk;
            c_OP_SUB: Result = Vj - Vk;
            c_OP_AND: Result = Vj & Vk;
            c_OP_OR:  Result = Vj | Vk;
            default:  Result = Vj;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station
//  Description : Single-entry Tomasulo reservation station. Accepts one
//                instruction, snoops the CDB for missing operands, executes
//                for EXEC_LATENCY cycles and requests the CDB until granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter logic [2:0] RS_TAG       = c_RES_STATION_ADD1,
    parameter int         EXEC_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable_VQ,
    input  logic [2:0]  Opcode,
    input  logic [15:0] Vj,
    input  logic [15:0] Vk,
    input  logic [2:0]  Qj,
    input  logic [2:0]  Qk,
    input  logic        CDB_Valid,
    input  logic [2:0]  CDB_Tag,
    input  logic [15:0] CDB_Data,
    input  logic        CDB_Grant,
    output logic        Ready,
    output logic        Busy,
    output logic        Result_Valid,
    output logic [2:0]  Result_Tag,
    output logic [15:0] Result_Data
);

    localparam logic [2:0] c_LATENCY = EXEC_LATENCY[2:0];

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_opcode;
    logic [15:0] r_vj;
    logic [15:0] r_vk;
    logic [2:0]  r_qj;
    logic [2:0]  r_qk;
    logic [2:0]  r_count;
    logic [15:0] r_result;
    logic [15:0] w_alu_result;

    logic        w_load;
    logic        w_snoop_en;
    logic [2:0]  w_qj_src;
    logic [2:0]  w_qk_src;
    logic [15:0] w_vj_src;
    logic [15:0] w_vk_src;
    logic        w_hit_j;
    logic        w_hit_k;
    logic [2:0]  w_qj_after;
    logic [2:0]  w_qk_after;
    logic        w_ops_ready;

    // A new instruction is taken only while free and only if it is not a NOP
    assign w_load     = (r_state == c_ST_IDLE) && Enable_VQ && (Opcode != c_OP_NOP);
    assign w_snoop_en = w_load || (r_state == c_ST_WAIT_OPS);

    // During the load edge the dispatch bus is the operand source; afterwards
    // the latched copies are
    assign w_qj_src = (r_state == c_ST_IDLE) ? Qj : r_qj;
    assign w_qk_src = (r_state == c_ST_IDLE) ? Qk : r_qk;
    assign w_vj_src = (r_state == c_ST_IDLE) ? Vj : r_vj;
    assign w_vk_src = (r_state == c_ST_IDLE) ? Vk : r_vk;

    assign w_hit_j     = w_snoop_en && f_tag_hit(CDB_Valid, CDB_Tag, w_qj_src);
    assign w_hit_k     = w_snoop_en && f_tag_hit(CDB_Valid, CDB_Tag, w_qk_src);
    assign w_qj_after  = w_hit_j ? c_FREE_REGISTER : w_qj_src;
    assign w_qk_after  = w_hit_k ? c_FREE_REGISTER : w_qk_src;
    assign w_ops_ready = (w_qj_after == c_FREE_REGISTER) && (w_qk_after == c_FREE_REGISTER);

    rs_alu u_alu (
        .Opcode (r_opcode),
        .Vj     (r_vj),
        .Vk     (r_vk),
        .Result (w_alu_result)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_load) begin
                    w_next_state = w_ops_ready ? c_ST_EXEC : c_ST_WAIT_OPS;
                end
            end
            c_ST_WAIT_OPS: begin
                if (w_ops_ready) begin
                    w_next_state = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (r_count == 3'd1) begin
                    w_next_state = c_ST_BROADCAST;
                end
            end
            c_ST_BROADCAST: begin
                if (CDB_Grant) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Operand capture, execute countdown and result register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_opcode <= c_OP_NOP;
            r_vj     <= c_OPERAND_SENTINEL;
            r_vk     <= c_OPERAND_SENTINEL;
            r_qj     <= c_FREE_REGISTER;
            r_qk     <= c_FREE_REGISTER;
            r_count  <= 3'd0;
            r_result <= 16'd0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_WAIT_OPS: begin
                    if (w_snoop_en) begin
                        if (w_load) begin
                            r_opcode <= Opcode;
                        end
                        r_vj <= w_hit_j ? CDB_Data : w_vj_src;
                        r_vk <= w_hit_k ? CDB_Data : w_vk_src;
                        r_qj <= w_qj_after;
                        r_qk <= w_qk_after;
                        if (w_ops_ready) begin
                            r_count <= c_LATENCY;
                        end
                    end
                end
                c_ST_EXEC: begin
                    if (r_count == 3'd1) begin
                        r_result <= w_alu_result;
                        r_count  <= 3'd0;
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                c_ST_BROADCAST: begin
                    if (CDB_Grant) begin
                        r_vj <= c_OPERAND_SENTINEL;
                        r_vk <= c_OPERAND_SENTINEL;
                        r_qj <= c_FREE_REGISTER;
                        r_qk <= c_FREE_REGISTER;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Ready        = (r_state == c_ST_IDLE);
    assign Busy         = ~Ready;
    assign Result_Valid = (r_state == c_ST_BROADCAST);
    assign Result_Tag   = Result_Valid ? RS_TAG : c_FREE_REGISTER;
    assign Result_Data  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reservation_station
//  Description : Directed self-checking bench for reservation_station with a
//                cycle-level behavioural model and literal spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

    localparam logic [2:0] c_TAG = 3'd1;
    localparam int         c_LAT = 2;

    logic        clk = 1'b0;
    logic        r_reset = 1'b1;
    logic        r_en = 1'b0;
    logic [2:0]  r_op = 3'd0;
    logic [15:0] r_vj = 16'd0;
    logic [15:0] r_vk = 16'd0;
    logic [2:0]  r_qj = 3'd0;
    logic [2:0]  r_qk = 3'd0;
    logic        r_cdb_v = 1'b0;
    logic [2:0]  r_cdb_tag = 3'd0;
    logic [15:0] r_cdb_data = 16'd0;
    logic        r_grant = 1'b0;

    logic        w_ready;
    logic        w_busy;
    logic        w_valid;
    logic [2:0]  w_tag;
    logic [15:0] w_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: one pending instruction, its operands and tags,
    // remaining execute cycles, and whether it is requesting the bus
    bit          m_inst = 1'b0;
    bit          m_bcast = 1'b0;
    logic [2:0]  m_op = 3'd0;
    logic [15:0] m_a = 16'd0;
    logic [15:0] m_b = 16'd0;
    logic [2:0]  m_ta = 3'd0;
    logic [2:0]  m_tb = 3'd0;
    int          m_left = 0;
    logic [15:0] m_res = 16'd0;

    reservation_station #(
        .RS_TAG       (c_TAG),
        .EXEC_LATENCY (c_LAT)
    ) dut (
        .Clock        (clk),
        .Reset        (r_reset),
        .Enable_VQ    (r_en),
        .Opcode       (r_op),
        .Vj           (r_vj),
        .Vk           (r_vk),
        .Qj           (r_qj),
        .Qk           (r_qk),
        .CDB_Valid    (r_cdb_v),
        .CDB_Tag      (r_cdb_tag),
        .CDB_Data     (r_cdb_data),
        .CDB_Grant    (r_grant),
        .Ready        (w_ready),
        .Busy         (w_busy),
        .Result_Valid (w_valid),
        .Result_Tag   (w_tag),
        .Result_Data  (w_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] golden(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        case (op)
            3'd1: begin t = {1'b0, a} + {1'b0, b}; return t[15:0]; end
            3'd2: begin t = {1'b0, a} + {1'b0, ~b} + 17'd1; return t[15:0]; end
            3'd3: return a & b;
            3'd4: return a | b;
            default: return a;
        endcase
    endfunction

    function automatic bit hit(input logic [2:0] q);
        return r_cdb_v && (r_cdb_tag != 3'd0) && (r_cdb_tag == q);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every rising edge from the bench-driven inputs
    always @(posedge clk) begin
        if (r_reset) begin
            m_inst = 1'b0; m_bcast = 1'b0; m_res = 16'd0; m_left = 0;
        end else if (!m_inst) begin
            if (r_en && r_op != 3'd0) begin
                m_inst = 1'b1;
                m_op   = r_op;
                m_a    = hit(r_qj) ? r_cdb_data : r_vj;
                m_b    = hit(r_qk) ? r_cdb_data : r_vk;
                m_ta   = hit(r_qj) ? 3'd0 : r_qj;
                m_tb   = hit(r_qk) ? 3'd0 : r_qk;
                m_left = (m_ta == 0 && m_tb == 0) ? c_LAT : 0;
            end
        end else if (m_bcast) begin
            if (r_grant) begin
                m_inst = 1'b0; m_bcast = 1'b0;
            end
        end else if (m_ta != 0 || m_tb != 0) begin
            if (hit(m_ta)) begin m_a = r_cdb_data; m_ta = 3'd0; end
            if (hit(m_tb)) begin m_b = r_cdb_data; m_tb = 3'd0; end
            if (m_ta == 0 && m_tb == 0) m_left = c_LAT;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_bcast = 1'b1;
                m_res   = golden(m_op, m_a, m_b);
            end
        end
    end

    // Compare DUT outputs against the model shortly after every edge
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model_ready", {31'd0, w_ready}, {31'd0, !m_inst});
            check("model_busy",  {31'd0, w_busy},  {31'd0, m_inst});
            check("model_valid", {31'd0, w_valid}, {31'd0, m_bcast});
            check("model_tag",   {29'd0, w_tag},   {29'd0, (m_bcast ? c_TAG : 3'd0)});
            check("model_data",  {16'd0, w_data},  {16'd0, m_res});
        end
    end

    task automatic load(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] ta, input logic [2:0] tb_,
                        input logic fv, input logic [2:0] ftag, input logic [15:0] fdata);
        @(negedge clk);
        r_en = 1'b1; r_op = op; r_vj = a; r_vk = b; r_qj = ta; r_qk = tb_;
        r_cdb_v = fv; r_cdb_tag = ftag; r_cdb_data = fdata;
        @(negedge clk);
        r_en = 1'b0; r_op = 3'd0; r_cdb_v = 1'b0; r_cdb_tag = 3'd0;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
        @(negedge clk);
        r_cdb_v = 1'b1; r_cdb_tag = tag; r_cdb_data = data;
        @(negedge clk);
        r_cdb_v = 1'b0; r_cdb_tag = 3'd0;
    endtask

    task automatic wait_bcast(input string name, input int max, output int edges);
        edges = 0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (w_valid) break;
        end
        if (!w_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: actual=no broadcast required=broadcast within %0d edges", name, max);
        end
    endtask

    task automatic grant_and_check(input string name);
        @(negedge clk);
        r_grant = 1'b1;
        @(negedge clk);
        r_grant = 1'b0;
        check({name, "_ready_after_grant"}, {31'd0, w_ready}, 32'd1);
        check({name, "_tag_after_grant"}, {29'd0, w_tag}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        int e;
        load(op, a, b, 3'd0, 3'd0, 1'b0, 3'd0, 16'd0);
        wait_bcast(name, 10, e);
        check({name, "_data"}, {16'd0, w_data}, {16'd0, exp});
        grant_and_check(name);
    endtask

    initial begin
        int e;
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        // Reset state
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        r_reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, w_ready}, 32'd1);
        check("rst_busy",  {31'd0, w_busy},  32'd0);
        check("rst_valid", {31'd0, w_valid}, 32'd0);
        check("rst_tag",   {29'd0, w_tag},   32'd0);
        check("rst_data",  {16'd0, w_data},  32'd0);

        // ADD 5+7, fixed latency, held broadcast, ignored busy load
        load(3'd1, 16'd5, 16'd7, 3'd0, 3'd0, 1'b0, 3'd0, 16'd0);
        check("add_ready_low", {31'd0, w_ready}, 32'd0);
        wait_bcast("add", 10, e);
        check("add_latency", e, 32'd2);
        check("add_data", {16'd0, w_data}, 32'd12);
        check("add_tag",  {29'd0, w_tag},  32'd1);
        check("add_model_res", {16'd0, m_res}, 32'd12);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r_en = (i == 1); r_op = (i == 1) ? 3'd1 : 3'd0; r_vj = 16'd100; r_vk = 16'd100;
            check("hold_valid", {31'd0, w_valid}, 32'd1);
            check("hold_data",  {16'd0, w_data},  32'd12);
            check("hold_tag",   {29'd0, w_tag},   32'd1);
        end
        @(negedge clk);
        r_en = 1'b0; r_op = 3'd0;
        grant_and_check("add");

        // SUB waiting on tag 2; tag 0 and foreign tag ignored
        load(3'd2, 16'd0, 16'd3, 3'd2, 3'd0, 1'b0, 3'd0, 16'd0);
        cdb(3'd0, 16'd50);
        cdb(3'd1, 16'd60);
        @(negedge clk);
        check("sub_wait_valid", {31'd0, w_valid}, 32'd0);
        cdb(3'd2, 16'd10);
        wait_bcast("sub_dep", 10, e);
        check("sub_dep_data", {16'd0, w_data}, 32'd7);
        grant_and_check("sub_dep");

        // Same-cycle forwarding skips the wait
        load(3'd1, 16'd0, 16'd1, 3'd2, 3'd0, 1'b1, 3'd2, 16'd9);
        wait_bcast("fwd", 10, e);
        check("fwd_latency", e, 32'd2);
        check("fwd_data", {16'd0, w_data}, 32'd10);
        grant_and_check("fwd");

        // Wrap boundaries and remaining opcodes
        run_op("add_wrap", 3'd1, 16'hFFFF, 16'h0001, 16'h0000);
        run_op("sub_wrap", 3'd2, 16'h0000, 16'h0001, 16'hFFFF);
        run_op("and",      3'd3, 16'hF0F0, 16'h3C3C, 16'h3030);
        run_op("or",       3'd4, 16'hF000, 16'h000F, 16'hF00F);
        run_op("pass",     3'd6, 16'h1234, 16'h5678, 16'h1234);

        // One broadcast satisfies both operands
        load(3'd1, 16'd0, 16'd0, 3'd2, 3'd2, 1'b0, 3'd0, 16'd0);
        @(negedge clk);
        cdb(3'd2, 16'd4);
        wait_bcast("dual", 10, e);
        check("dual_data", {16'd0, w_data}, 32'd8);
        grant_and_check("dual");

        // NOP ignored
        load(3'd0, 16'd1, 16'd1, 3'd0, 3'd0, 1'b0, 3'd0, 16'd0);
        check("nop_ready", {31'd0, w_ready}, 32'd1);

        // Reset during execute abandons the instruction
        load(3'd1, 16'd2, 16'd2, 3'd0, 3'd0, 1'b0, 3'd0, 16'd0);
        r_reset = 1'b1; r_grant = 1'b1;
        @(negedge clk);
        r_reset = 1'b0; r_grant = 1'b0;
        check("rst_exec_ready", {31'd0, w_ready}, 32'd1);
        check("rst_exec_valid", {31'd0, w_valid}, 32'd0);
        repeat (4) @(negedge clk);
        check("rst_exec_no_bcast", {31'd0, w_valid}, 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
